// File: rtl/tl_ul_fragmenter_gen_if.sv
// TileLink-UL channel A/D bundle for the fragmenter's inbound and outbound ports.
// master drives A and consumes D; slave accepts A and returns D.
interface tl_ul_fragmenter_gen_if #(
    parameter int BEAT_BYTES = 4,
    parameter int ADDR_W     = 17,
    parameter int SRC_W      = 5,
    parameter int SIZE_W     = 3
);
    logic                    a_valid;
    logic                    a_ready;
    logic [2:0]              a_opcode;
    logic [SIZE_W-1:0]       a_size;
    logic [SRC_W-1:0]        a_source;
    logic [ADDR_W-1:0]       a_address;
    logic [BEAT_BYTES-1:0]   a_mask;
    logic [8*BEAT_BYTES-1:0] a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [2:0]              d_opcode;
    logic [SIZE_W-1:0]       d_size;
    logic [SRC_W-1:0]        d_source;
    logic                    d_denied;
    logic [8*BEAT_BYTES-1:0] d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );
endinterface

// File: rtl/tl_ul_fragmenter_gen.sv
// TileLink-UL fragmenter: splits multi-beat Get/Put into single-beat requests and folds the
// D responses back. Optional macro TL_FRAG_DENY_MERGE_EN merges denied over dropped Put acks.
module tl_ul_fragmenter_gen #(
    parameter int BEAT_BYTES = 4,
    parameter int ADDR_W     = 17,
    parameter int SRC_W      = 5,
    parameter int SIZE_W     = 3,
    parameter int MAX_LG     = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_ul_fragmenter_gen_if.slave  in_bus,
    tl_ul_fragmenter_gen_if.master out_bus
);
    localparam int LG_BEAT = $clog2(BEAT_BYTES);
    localparam int FRAG_W  = (MAX_LG - LG_BEAT > 1) ? (MAX_LG - LG_BEAT) : 1;
    localparam int OSIZE_W = (LG_BEAT > 3) ? 3 : 2;

    localparam logic [2:0] OP_GET = 3'd4;
    localparam logic [2:0] OP_ACK = 3'd0;

    localparam logic [FRAG_W-1:0] FRAG_ONE = 1;
    localparam logic [FRAG_W:0]   BEAT_ONE = 1;

    typedef enum logic {IDLE, GET_BURST} state_t;

    // Beats in a message minus one; also the first "remaining" value.
    function automatic logic [FRAG_W-1:0] beats_m1(input logic [SIZE_W-1:0] size);
        logic [FRAG_W:0] n;
        logic [FRAG_W:0] nm;
        if (int'(size) > LG_BEAT) n = BEAT_ONE << (int'(size) - LG_BEAT);
        else                      n = BEAT_ONE;
        nm = n - BEAT_ONE;
        return nm[FRAG_W-1:0];
    endfunction

    state_t             state_q;
    logic [FRAG_W-1:0]  rem_q;
    logic [FRAG_W-1:0]  last_q;
    logic [ADDR_W-1:0]  base_q;
    logic [SRC_W-1:0]   src_q;
    logic               put_first_q;
    logic [FRAG_W-1:0]  put_rem_q;

    logic [FRAG_W-1:0]  in_n_m1;
    logic               in_is_get;
    logic               in_is_get_burst;
    logic [FRAG_W-1:0]  a_rem;
    logic [FRAG_W-1:0]  a_last;
    logic [ADDR_W-1:0]  a_base;
    logic [SRC_W-1:0]   a_src;
    logic               a_fire;
    logic               first_fire;

    assign in_n_m1         = beats_m1(in_bus.a_size);
    assign in_is_get       = (in_bus.a_opcode == OP_GET);
    assign in_is_get_burst = in_is_get && (in_n_m1 != '0);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        out_bus.a_valid  = in_bus.a_valid;
        out_bus.a_opcode = in_bus.a_opcode;
        out_bus.a_mask   = in_bus.a_mask;
        out_bus.a_data   = in_bus.a_data;
        out_bus.a_size   = (int'(in_bus.a_size) > LG_BEAT) ? OSIZE_W'(LG_BEAT)
                                                           : OSIZE_W'(in_bus.a_size);
        in_bus.a_ready   = out_bus.a_ready;
        a_base           = in_bus.a_address;
        a_src            = in_bus.a_source;
        a_last           = in_n_m1;
        a_rem            = put_first_q ? in_n_m1 : put_rem_q;

        if (state_q == GET_BURST) begin
            out_bus.a_valid  = 1'b1;
            out_bus.a_opcode = OP_GET;
            out_bus.a_mask   = '1;
            out_bus.a_data   = '0;
            out_bus.a_size   = OSIZE_W'(LG_BEAT);
            a_base           = base_q;
            a_src            = src_q;
            a_last           = last_q;
            a_rem            = rem_q;
            in_bus.a_ready   = (rem_q == '0) ? out_bus.a_ready : 1'b0;
        end else if (in_is_get) begin
            a_rem          = in_n_m1;
            in_bus.a_ready = in_is_get_burst ? 1'b0 : out_bus.a_ready;
        end

        if (!reset) begin
            out_bus.a_valid = 1'b0;
            in_bus.a_ready  = 1'b0;
        end
    end

    assign out_bus.a_source  = {a_src, a_rem};
    assign out_bus.a_address = a_base + (ADDR_W'(a_last - a_rem) << LG_BEAT);

    assign a_fire     = out_bus.a_valid && out_bus.a_ready;
    assign first_fire = a_fire && (state_q == IDLE) && (in_is_get || put_first_q);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            last_q      <= '0;
            base_q      <= '0;
            src_q       <= '0;
            put_first_q <= 1'b1;
            put_rem_q   <= '0;
        end else if (a_fire) begin
            unique case (state_q)
                IDLE: begin
                    if (in_is_get_burst) begin
                        state_q <= GET_BURST;
                        rem_q   <= in_n_m1 - FRAG_ONE;
                        last_q  <= in_n_m1;
                        base_q  <= in_bus.a_address;
                        src_q   <= in_bus.a_source;
                    end else if (!in_is_get) begin
                        put_first_q <= (a_rem == '0);
                        put_rem_q   <= a_rem - FRAG_ONE;
                    end
                end
                GET_BURST: begin
                    if (rem_q == '0) state_q <= IDLE;
                    else             rem_q   <= rem_q - FRAG_ONE;
                end
            endcase
        end
    end

    // NOTE: the size table has no reset; an entry is always written by the first fragment
    // of a message before any response to that message can read it.
    logic [SIZE_W-1:0] size_tab [2**SRC_W];

    always_ff @(posedge clock) begin
        if (first_fire) size_tab[in_bus.a_source] <= in_bus.a_size;
    end

    logic [SRC_W-1:0]  d_src;
    logic [FRAG_W-1:0] d_rem;
    logic              d_drop;

    assign d_src  = out_bus.d_source[SRC_W+FRAG_W-1 -: SRC_W];
    assign d_rem  = out_bus.d_source[FRAG_W-1:0];
    // Only the last ack of a fragmented Put reaches the master; earlier ones are absorbed.
    assign d_drop = (out_bus.d_opcode == OP_ACK) && (d_rem != '0);

    assign in_bus.d_valid   = reset && out_bus.d_valid && !d_drop;
    assign out_bus.d_ready  = d_drop || in_bus.d_ready;
    assign in_bus.d_opcode  = out_bus.d_opcode;
    assign in_bus.d_size    = size_tab[d_src];
    assign in_bus.d_source  = d_src;
    assign in_bus.d_data    = out_bus.d_data;

`ifdef TL_FRAG_DENY_MERGE_EN
    logic [2**SRC_W-1:0] deny_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            deny_q <= '0;
        end else if (out_bus.d_valid && d_drop) begin
            deny_q[d_src] <= deny_q[d_src] | out_bus.d_denied;
        end else if (in_bus.d_valid && in_bus.d_ready && (out_bus.d_opcode == OP_ACK)) begin
            deny_q[d_src] <= 1'b0;
        end
    end

    assign in_bus.d_denied = out_bus.d_denied | ((out_bus.d_opcode == OP_ACK) && deny_q[d_src]);
`else
    assign in_bus.d_denied = out_bus.d_denied;
`endif
endmodule

// File: tb/tb_tl_ul_fragmenter_gen.sv
// Scoreboard bench for tl_ul_fragmenter_gen: directed requests push expected fragments and
// responses; two monitors pop and compare on every outbound A fire and inbound D fire.
module tb_tl_ul_fragmenter_gen;
    localparam int BEAT_BYTES = 4;
    localparam int ADDR_W     = 17;
    localparam int SRC_W      = 5;
    localparam int SIZE_W     = 3;
    localparam int OSRC_W     = 8;

`ifdef TL_FRAG_DENY_MERGE_EN
    localparam logic DENY_EXP = 1'b1;
`else
    localparam logic DENY_EXP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tl_ul_fragmenter_gen_if #(.BEAT_BYTES(BEAT_BYTES), .ADDR_W(ADDR_W), .SRC_W(SRC_W),
                              .SIZE_W(SIZE_W)) in_if ();
    tl_ul_fragmenter_gen_if #(.BEAT_BYTES(BEAT_BYTES), .ADDR_W(ADDR_W), .SRC_W(OSRC_W),
                              .SIZE_W(2)) out_if ();

    tl_ul_fragmenter_gen #(.BEAT_BYTES(BEAT_BYTES), .ADDR_W(ADDR_W), .SRC_W(SRC_W),
                           .SIZE_W(SIZE_W), .MAX_LG(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .in_bus  (in_if),
        .out_bus (out_if)
    );

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [16:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        rdy;
    } a_exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [4:0]  src;
        logic        denied;
        logic [31:0] data;
    } d_exp_t;

    a_exp_t a_q[$];
    d_exp_t d_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    a_exp_t ea;
    always @(negedge clock) begin
        if (out_if.a_valid && out_if.a_ready) begin
            if (a_q.size() == 0) begin
                check("a_unexpected_fire", 64'd1, 64'd0);
            end else begin
                ea = a_q.pop_front();
                check("a_opcode",   64'(out_if.a_opcode),  64'(ea.op));
                check("a_source",   64'(out_if.a_source),  64'(ea.src));
                check("a_address",  64'(out_if.a_address), 64'(ea.addr));
                check("a_size",     64'(out_if.a_size),    64'(ea.size));
                check("a_mask",     64'(out_if.a_mask),    64'(ea.mask));
                check("a_data",     64'(out_if.a_data),    64'(ea.data));
                check("a_in_ready", 64'(in_if.a_ready),    64'(ea.rdy));
            end
        end
    end

    d_exp_t ed;
    always @(negedge clock) begin
        if (in_if.d_valid && in_if.d_ready) begin
            if (d_q.size() == 0) begin
                check("d_unexpected_fire", 64'd1, 64'd0);
            end else begin
                ed = d_q.pop_front();
                check("d_opcode", 64'(in_if.d_opcode), 64'(ed.op));
                check("d_size",   64'(in_if.d_size),   64'(ed.size));
                check("d_source", 64'(in_if.d_source), 64'(ed.src));
                check("d_denied", 64'(in_if.d_denied), 64'(ed.denied));
                check("d_data",   64'(in_if.d_data),   64'(ed.data));
            end
        end
    end

    task automatic push_a(input logic [2:0] op, input logic [7:0] src, input logic [16:0] addr,
                          input logic [1:0] size, input logic [3:0] mask, input logic [31:0] data,
                          input logic rdy);
        a_exp_t e;
        e.op = op; e.src = src; e.addr = addr; e.size = size;
        e.mask = mask; e.data = data; e.rdy = rdy;
        a_q.push_back(e);
    endtask

    task automatic push_d(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                          input logic denied, input logic [31:0] data);
        d_exp_t e;
        e.op = op; e.size = size; e.src = src; e.denied = denied; e.data = data;
        d_q.push_back(e);
    endtask

    // Present one inbound A beat and hold it until the fragmenter accepts it.
    task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                           input logic [16:0] addr, input logic [3:0] mask, input logic [31:0] data,
                           input bit toggle);
        bit done = 1'b0;
        in_if.a_valid = 1'b1; in_if.a_opcode = op; in_if.a_size = size; in_if.a_source = src;
        in_if.a_address = addr; in_if.a_mask = mask; in_if.a_data = data;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (in_if.a_valid && in_if.a_ready) begin
                done = 1'b1;
            end else begin
                @(posedge clock); #1;
                if (toggle) out_if.a_ready = ~out_if.a_ready;
            end
        end
        check("a_accept_in_time", 64'(done), 64'd1);
        @(posedge clock); #1;
        in_if.a_valid = 1'b0;
        out_if.a_ready = 1'b1;
    endtask

    // Slave returns one D beat; in_d_ready is held low for 'stall' cycles first.
    task automatic slave_d(input logic [2:0] op, input logic [7:0] src, input logic denied,
                           input logic [31:0] data, input int stall);
        bit done = 1'b0;
        int left = stall;
        logic drop;
        drop = (op == 3'd0) && (src[2:0] != 3'd0);
        out_if.d_valid = 1'b1; out_if.d_opcode = op; out_if.d_size = 2'd2;
        out_if.d_source = src; out_if.d_denied = denied; out_if.d_data = data;
        in_if.d_ready = (left == 0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (left > 0) begin
                check("d_stall_out_ready", 64'(out_if.d_ready), 64'(drop));
                check("d_stall_in_valid",  64'(in_if.d_valid),  64'(!drop));
            end
            if (out_if.d_valid && out_if.d_ready) begin
                done = 1'b1;
            end else begin
                @(posedge clock); #1;
                if (left > 0) left--;
                in_if.d_ready = (left == 0);
            end
        end
        check("d_accept_in_time", 64'(done), 64'd1);
        @(posedge clock); #1;
        out_if.d_valid = 1'b0;
        in_if.d_ready = 1'b1;
    endtask

    initial begin
        int fires;
        in_if.a_valid = 1'b0; in_if.a_opcode = 3'd4; in_if.a_size = 3'd2; in_if.a_source = '0;
        in_if.a_address = '0; in_if.a_mask = 4'hF; in_if.a_data = '0; in_if.d_ready = 1'b1;
        out_if.a_ready = 1'b1; out_if.d_valid = 1'b0; out_if.d_opcode = 3'd1; out_if.d_size = 2'd2;
        out_if.d_source = '0; out_if.d_denied = 1'b0; out_if.d_data = '0;

        // Reset holds both valids low even with live inputs.
        #1;
        in_if.a_valid = 1'b1;
        out_if.d_valid = 1'b1;
        @(negedge clock);
        check("reset_out_a_valid", 64'(out_if.a_valid), 64'd0);
        check("reset_in_d_valid",  64'(in_if.d_valid),  64'd0);
        @(posedge clock); #1;
        in_if.a_valid = 1'b0;
        out_if.d_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // 16-byte Get -> four single-beat Gets, four data beats back with size 4.
        push_a(3'd4, 8'h1B, 17'h100, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h1A, 17'h104, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h19, 17'h108, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h18, 17'h10C, 2'd2, 4'hF, 32'h0, 1'b1);
        drive_a(3'd4, 3'd4, 5'd3, 17'h100, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_d(3'd1, 3'd4, 5'd3, 1'b0, 32'hD000_0000 + 32'(i));
            slave_d(3'd1, {5'd3, 3'(3 - i)}, 1'b0, 32'hD000_0000 + 32'(i), 0);
        end

        // Two-beat PutFull -> two Puts, one forwarded ack with size 3.
        push_a(3'd0, 8'h29, 17'h200, 2'd2, 4'hF, 32'hA, 1'b1);
        push_a(3'd0, 8'h28, 17'h204, 2'd2, 4'hF, 32'hB, 1'b1);
        drive_a(3'd0, 3'd3, 5'd5, 17'h200, 4'hF, 32'hA, 1'b0);
        drive_a(3'd0, 3'd3, 5'd5, 17'h200, 4'hF, 32'hB, 1'b0);
        slave_d(3'd0, 8'h29, 1'b0, 32'h0, 0);
        push_d(3'd0, 3'd3, 5'd5, 1'b0, 32'h0);
        slave_d(3'd0, 8'h28, 1'b0, 32'h0, 0);

        // Single-beat and sub-beat requests pass straight through.
        push_a(3'd4, 8'h38, 17'h040, 2'd2, 4'hF, 32'h0, 1'b1);
        drive_a(3'd4, 3'd2, 5'd7, 17'h040, 4'hF, 32'h0, 1'b0);
        push_d(3'd1, 3'd2, 5'd7, 1'b0, 32'h1234_5678);
        slave_d(3'd1, 8'h38, 1'b0, 32'h1234_5678, 0);
        push_a(3'd4, 8'h38, 17'h042, 2'd1, 4'hC, 32'h0, 1'b1);
        drive_a(3'd4, 3'd1, 5'd7, 17'h042, 4'hC, 32'h0, 1'b0);
        push_d(3'd1, 3'd1, 5'd7, 1'b0, 32'hABCD_0000);
        slave_d(3'd1, 8'h38, 1'b0, 32'hABCD_0000, 0);
        push_a(3'd1, 8'h48, 17'h080, 2'd2, 4'h5, 32'h0000_CAFE, 1'b1);
        drive_a(3'd1, 3'd2, 5'd9, 17'h080, 4'h5, 32'h0000_CAFE, 1'b0);
        push_d(3'd0, 3'd2, 5'd9, 1'b0, 32'h0);
        slave_d(3'd0, 8'h48, 1'b0, 32'h0, 0);

        // 32-byte Get with out_a_ready toggling every cycle; first data beat stalled.
        for (int i = 0; i < 8; i++)
            push_a(3'd4, {5'd1, 3'(7 - i)}, 17'h3E0 + 17'(4 * i), 2'd2, 4'hF, 32'h0, 1'(i == 7));
        drive_a(3'd4, 3'd5, 5'd1, 17'h3E0, 4'hF, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            push_d(3'd1, 3'd5, 5'd1, 1'b0, 32'hBEEF_0000 + 32'(i));
            slave_d(3'd1, {5'd1, 3'(7 - i)}, 1'b0, 32'hBEEF_0000 + 32'(i), (i == 0) ? 2 : 0);
        end

        // Dropped ack is taken even with in_d_ready low; the final one waits for it.
        push_a(3'd0, 8'h11, 17'h300, 2'd2, 4'hF, 32'h1, 1'b1);
        push_a(3'd0, 8'h10, 17'h304, 2'd2, 4'hF, 32'h2, 1'b1);
        drive_a(3'd0, 3'd3, 5'd2, 17'h300, 4'hF, 32'h1, 1'b0);
        drive_a(3'd0, 3'd3, 5'd2, 17'h300, 4'hF, 32'h2, 1'b0);
        slave_d(3'd0, 8'h11, 1'b0, 32'h0, 2);
        push_d(3'd0, 3'd3, 5'd2, 1'b0, 32'h0);
        slave_d(3'd0, 8'h10, 1'b0, 32'h0, 1);

        // Reset after two of four fragments; the next Get restarts from remaining = 3.
        push_a(3'd4, 8'h23, 17'h500, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h22, 17'h504, 2'd2, 4'hF, 32'h0, 1'b0);
        in_if.a_valid = 1'b1; in_if.a_opcode = 3'd4; in_if.a_size = 3'd4; in_if.a_source = 5'd4;
        in_if.a_address = 17'h500; in_if.a_mask = 4'hF; in_if.a_data = 32'h0;
        fires = 0;
        for (int i = 0; i < 50 && fires < 2; i++) begin
            @(negedge clock);
            if (out_if.a_valid && out_if.a_ready) fires++;
            if (fires < 2) begin @(posedge clock); #1; end
        end
        check("reset_fires_before", 64'(fires), 64'd2);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("reset_mid_burst_valid", 64'(out_if.a_valid), 64'd0);
        @(posedge clock); #1 in_if.a_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        push_a(3'd4, 8'h23, 17'h600, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h22, 17'h604, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h21, 17'h608, 2'd2, 4'hF, 32'h0, 1'b0);
        push_a(3'd4, 8'h20, 17'h60C, 2'd2, 4'hF, 32'h0, 1'b1);
        drive_a(3'd4, 3'd4, 5'd4, 17'h600, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_d(3'd1, 3'd4, 5'd4, 1'b0, 32'h6000_0000 + 32'(i));
            slave_d(3'd1, {5'd4, 3'(3 - i)}, 1'b0, 32'h6000_0000 + 32'(i), 0);
        end

        // Four-beat Put, only the first ack denied.
        for (int i = 0; i < 4; i++)
            push_a(3'd0, {5'd6, 3'(3 - i)}, 17'h700 + 17'(4 * i), 2'd2, 4'hF, 32'h10 + 32'(i), 1'b1);
        for (int i = 0; i < 4; i++)
            drive_a(3'd0, 3'd4, 5'd6, 17'h700, 4'hF, 32'h10 + 32'(i), 1'b0);
        slave_d(3'd0, 8'h33, 1'b1, 32'h0, 0);
        slave_d(3'd0, 8'h32, 1'b0, 32'h0, 0);
        slave_d(3'd0, 8'h31, 1'b0, 32'h0, 0);
        push_d(3'd0, 3'd4, 5'd6, DENY_EXP, 32'h0);
        slave_d(3'd0, 8'h30, 1'b0, 32'h0, 0);

        // Following Put on the same source sees a clean flag; a Get beat carries its own denied.
        push_a(3'd0, 8'h31, 17'h710, 2'd2, 4'hF, 32'h20, 1'b1);
        push_a(3'd0, 8'h30, 17'h714, 2'd2, 4'hF, 32'h21, 1'b1);
        drive_a(3'd0, 3'd3, 5'd6, 17'h710, 4'hF, 32'h20, 1'b0);
        drive_a(3'd0, 3'd3, 5'd6, 17'h710, 4'hF, 32'h21, 1'b0);
        slave_d(3'd0, 8'h31, 1'b0, 32'h0, 0);
        push_d(3'd0, 3'd3, 5'd6, 1'b0, 32'h0);
        slave_d(3'd0, 8'h30, 1'b0, 32'h0, 0);
        push_a(3'd4, 8'h30, 17'h720, 2'd2, 4'hF, 32'h0, 1'b1);
        drive_a(3'd4, 3'd2, 5'd6, 17'h720, 4'hF, 32'h0, 1'b0);
        push_d(3'd1, 3'd2, 5'd6, 1'b1, 32'h7777_0000);
        slave_d(3'd1, 8'h30, 1'b1, 32'h7777_0000, 0);

        repeat (3) @(posedge clock);
        check("a_queue_drained", 64'(a_q.size()), 64'd0);
        check("d_queue_drained", 64'(d_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tl_ul_fragmenter_gen.md
Name: tl_ul_fragmenter_gen

Overview:
- Parametrised TileLink-UL fragmenter for the periphery bus.
- Splits Get/PutFull/PutPartial requests larger than one beat into single-beat requests toward a single-beat slave.
- Reassembles D responses back into the original transaction.
- Generalises the fixed 32-bit/17-bit-address fragmenter instance: beat width, address width, source width and max transfer size are parameters. Adds D opcode/denied handling and per-source size tracking.

Parameters:
- BEAT_BYTES, 4, bytes per beat (power of 2, 4..16)
- ADDR_W, 17, address width
- SRC_W, 5, inbound source width
- SIZE_W, 3, inbound size width
- MAX_LG, 5, log2 of max transfer bytes (MAX_LG >= log2 BEAT_BYTES)
- FRAG_W, derived = max(1, MAX_LG - log2 BEAT_BYTES), fragment-index width

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low (0 = reset)
- in_a_valid/in_a_ready  in/out  1  A handshake
- in_a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get
- in_a_size  in  SIZE_W  log2 bytes
- in_a_source  in  SRC_W
- in_a_address  in  ADDR_W  aligned to size
- in_a_mask  in  BEAT_BYTES
- in_a_data  in  8*BEAT_BYTES
- in_d_valid/in_d_ready  out/in  1
- in_d_opcode  out  3  0 AccessAck, 1 AccessAckData
- in_d_size  out  SIZE_W
- in_d_source  out  SRC_W
- in_d_denied  out  1
- in_d_data  out  8*BEAT_BYTES
- out_a_valid/out_a_ready  out/in  1
- out_a_opcode  out  3
- out_a_size  out  2  always min(in size, log2 BEAT_BYTES)
- out_a_source  out  SRC_W+FRAG_W  {in_source, remaining}
- out_a_address  out  ADDR_W
- out_a_mask  out  BEAT_BYTES
- out_a_data  out  8*BEAT_BYTES
- out_d_valid/out_d_ready  in/out  1
- out_d_opcode  in  3
- out_d_size  in  2
- out_d_source  in  SRC_W+FRAG_W
- out_d_denied  in  1
- out_d_data  in  8*BEAT_BYTES

Behaviour:
- Beat count N = 2^(size - log2 BEAT_BYTES) if size > log2 BEAT_BYTES, else 1. Sizes above MAX_LG are illegal; the bench must not drive them.
- Fragment index "remaining" counts N-1 down to 0. out_a_source low FRAG_W bits = remaining; 0 marks the last fragment.
- out_a_address = base + (N-1-remaining)*BEAT_BYTES; no carry beyond ADDR_W.
- A FSM, states IDLE and GET_BURST:
  - IDLE, Get with N>1: out_a_valid = in_a_valid, in_a_ready = 0. On out fire, latch base/source/size and go to GET_BURST with remaining = N-2.
  - GET_BURST: emit one fragment per out_a fire, driven from the latched fields. On fire with remaining = 0: assert in_a_ready the same cycle (combinational, in_a_ready = out_a_ready), consume the input, return to IDLE.
  - Put: 1:1 beat pass-through; in_a_ready = out_a_ready. A put beat counter tracks remaining and reloads at the first beat of each message.
  - N=1: single pass-through, remaining = 0.
- Size table: SRC_W-indexed array of SIZE_W entries, written when the first fragment of a message fires.
- D path:
  - out_d_source upper bits give the in source; in_d_size = table[source].
  - AccessAckData: every beat is forwarded.
  - AccessAck with remaining != 0: dropped, with out_d_ready = 1 regardless of in_d_ready.
  - AccessAck with remaining = 0: forwarded.
  - Forwarded beats: out_d_ready = in_d_ready, zero added latency (combinational).
- Slave must return responses in order per source; not checked.
- Simultaneous A and D activity on the same source: the table write precedes the read only for a new message; responses to the old message never overlap a new one on the same source (TL rule).
- Reset (reset = 0 at a clock edge):
  - FSM returns to IDLE, counters cleared, sticky denied flags cleared; in-flight bursts are abandoned.
  - out_a_valid = 0 and in_d_valid = 0 while reset is low. Outputs are combinational from inputs except the FSM-driven ones.
  - Table contents are not reset.

Optional Feature:
- Macro TL_FRAG_DENY_MERGE_EN.
- Defined: per-source sticky denied flag is OR-ed over all dropped Put acks; the final ack reports (flag | out_d_denied). Get beats carry denied individually, and the flag clears on the final ack.
- Undefined: no flag storage; the final Put ack reports only its own out_d_denied.

Test Plan:
- Get size 4 (16 B), BEAT_BYTES 4, address 0x100, source 3 -> out_a: 4 Gets, addresses 0x100/104/108/10C, sources {3,3},{3,2},{3,1},{3,0}, size 2. in_a_ready high only on the 4th fire. 4 in_d beats with size 4, source 3.
- PutFull size 3, 2 beats, data 0xA, 0xB -> 2 out Puts carrying data 0xA, 0xB. 2 out acks -> exactly 1 in_d AccessAck, size 3.
- Get size 2 -> single pass-through, source {s,0}, size 2.
- Backpressure: out_a_ready toggles every cycle mid-burst -> fragment order and addresses unchanged, no duplicate fragments. in_d_ready = 0 -> out_d_ready = 0 except on dropped acks.
- Reset driven low after 2 of 4 Get fragments -> next cycle out_a_valid = 0. After release, a new Get starts at remaining = N-1.
- With TL_FRAG_DENY_MERGE_EN: 4-beat Put, first ack denied = 1, last denied = 0 -> in_d_denied = 1. Without the macro -> in_d_denied = 0.
